// File: rtl/mem_if_pkg.sv
// Shared definitions for the 8-bit async-style memory interface: initiator FSM states
// and the read/write pin encoding used by the initiator, the memory model and the bench.
package mem_if_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SETUP  = 2'd1,
    ACCESS = 2'd2,
    RESP   = 2'd3
  } state_e;

  localparam logic MEM_RW_READ  = 1'b1;
  localparam logic MEM_RW_WRITE = 1'b0;

endpackage

// File: rtl/mem_access_initiator.sv
// Single-outstanding memory initiator: accept edge to read response / next req_ready is
// WAIT_CYCLES+3 edges (accept edge included); req_ready drops while busy and RESP holds until rsp_ready.
module mem_access_initiator
  import mem_if_pkg::*;
#(
  parameter int unsigned ADDR_W      = 8,
  parameter int unsigned DATA_W      = 8,
  parameter int unsigned WAIT_CYCLES = 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_write,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [DATA_W-1:0] req_wdata,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic [DATA_W-1:0] rsp_rdata,
  output logic [ADDR_W-1:0] mem_address,
  output logic [DATA_W-1:0] mem_data_in,
  input  logic [DATA_W-1:0] mem_data_out,
  output logic              mem_read_write,
  output logic              mem_chip_en,
  output logic              busy
);

  localparam int unsigned CNT_W = (WAIT_CYCLES > 0) ? $clog2(WAIT_CYCLES + 1) : 1;
  localparam logic [CNT_W-1:0] CNT_INIT = CNT_W'(WAIT_CYCLES);

  state_e            state_q, state_d;
  logic [CNT_W-1:0]  wait_cnt_q, wait_cnt_d;
  logic              req_ready_q, req_ready_d;
  logic              rsp_valid_q, rsp_valid_d;
  logic [DATA_W-1:0] rsp_rdata_q, rsp_rdata_d;
  logic [ADDR_W-1:0] mem_address_q, mem_address_d;
  logic [DATA_W-1:0] mem_data_in_q, mem_data_in_d;
  logic              mem_rw_q, mem_rw_d;
  logic              mem_chip_en_q, mem_chip_en_d;
  logic              busy_q, busy_d;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q       <= IDLE;
      wait_cnt_q    <= '0;
      req_ready_q   <= 1'b1;
      rsp_valid_q   <= 1'b0;
      rsp_rdata_q   <= '0;
      mem_address_q <= '0;
      mem_data_in_q <= '0;
      mem_rw_q      <= MEM_RW_READ;
      mem_chip_en_q <= 1'b0;
      busy_q        <= 1'b0;
    end else begin
      state_q       <= state_d;
      wait_cnt_q    <= wait_cnt_d;
      req_ready_q   <= req_ready_d;
      rsp_valid_q   <= rsp_valid_d;
      rsp_rdata_q   <= rsp_rdata_d;
      mem_address_q <= mem_address_d;
      mem_data_in_q <= mem_data_in_d;
      mem_rw_q      <= mem_rw_d;
      mem_chip_en_q <= mem_chip_en_d;
      busy_q        <= busy_d;
    end
  end

  always_comb begin
    state_d       = state_q;
    wait_cnt_d    = wait_cnt_q;
    req_ready_d   = req_ready_q;
    rsp_valid_d   = rsp_valid_q;
    rsp_rdata_d   = rsp_rdata_q;
    mem_address_d = mem_address_q;
    mem_data_in_d = mem_data_in_q;
    mem_rw_d      = mem_rw_q;
    mem_chip_en_d = mem_chip_en_q;

    unique case (state_q)
      IDLE: begin
        if (req_valid && req_ready_q) begin
          mem_address_d = req_addr;
          mem_data_in_d = req_wdata;
          mem_rw_d      = req_write ? MEM_RW_WRITE : MEM_RW_READ;
          req_ready_d   = 1'b0;
          state_d       = SETUP;
        end
      end
      SETUP: begin
        // Pins have been stable for one chip_en-low cycle; open the access window.
        wait_cnt_d    = CNT_INIT;
        mem_chip_en_d = 1'b1;
        state_d       = ACCESS;
      end
      ACCESS: begin
        if (wait_cnt_q == '0) begin
          mem_chip_en_d = 1'b0;
          if (mem_rw_q == MEM_RW_READ) begin
            rsp_rdata_d = mem_data_out;
            rsp_valid_d = 1'b1;
            state_d     = RESP;
          end else begin
            req_ready_d = 1'b1;
            state_d     = IDLE;
          end
        end else begin
          wait_cnt_d = wait_cnt_q - CNT_W'(1);
        end
      end
      RESP: begin
        if (rsp_ready) begin
          rsp_valid_d = 1'b0;
          req_ready_d = 1'b1;
          state_d     = IDLE;
        end
      end
      default: begin
        mem_chip_en_d = 1'b0;
        rsp_valid_d   = 1'b0;
        req_ready_d   = 1'b1;
        state_d       = IDLE;
      end
    endcase

    busy_d = (state_d != IDLE);
  end

  assign req_ready      = req_ready_q;
  assign rsp_valid      = rsp_valid_q;
  assign rsp_rdata      = rsp_rdata_q;
  assign mem_address    = mem_address_q;
  assign mem_data_in    = mem_data_in_q;
  assign mem_read_write = mem_rw_q;
  assign mem_chip_en    = mem_chip_en_q;
  assign busy           = busy_q;

endmodule
